// File: rtl/bram_reg_access_gen.sv
// -----------------------------------------------------------------------------
// bram_reg_access_gen
//
// Makes one BRAM look like a block of 32-bit registers on a daisy-chained
// register ring. Each BRAM word is split into N = ceil(BRAM_DATA_WIDTH/32)
// 32-bit lanes. Lane writes go into a shadow word. Writing 32'h1 to lane N
// commits the shadow word to the addressed BRAM entry. A read of lane < N
// fetches the entry from the BRAM and returns the selected lane. A read of
// lane N returns the number of BRAM handshakes that timed out.
//
// Ring address layout (MSB to LSB):
//   {tag[TAG_WIDTH], unused, entry[BRAM_ADDR_WIDTH], lane[L]}
//
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   reg_*_in                 ring request arriving from upstream
//   reg_*_out                registered ring request passed downstream
//   wr_req/wr_addr/wr_data   BRAM write request, completed by wr_ack
//   rd_req/rd_addr           BRAM read request
//   rd_ack/rd_valid/rd_data  read accepted / read data valid, with the data
// -----------------------------------------------------------------------------
module bram_reg_access_gen #(
  parameter int                   UDP_REG_SRC_WIDTH = 2,
  parameter int                   REG_ADDR_WIDTH    = 23,
  parameter int                   TAG_WIDTH         = 10,
  parameter logic [TAG_WIDTH-1:0] TAG_ADDR          = 10'h025,
  parameter int                   BRAM_ADDR_WIDTH   = 10,
  parameter int                   BRAM_DATA_WIDTH   = 72,
  parameter int                   TIMEOUT_CYCLES    = 255
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         reg_req_in,
  input  logic                         reg_ack_in,
  input  logic                         reg_rd_wr_L_in,
  input  logic [REG_ADDR_WIDTH-1:0]    reg_addr_in,
  input  logic [31:0]                  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,

  output logic                         reg_req_out,
  output logic                         reg_ack_out,
  output logic                         reg_rd_wr_L_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_addr_out,
  output logic [31:0]                  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,

  output logic                         wr_req,
  output logic [BRAM_ADDR_WIDTH-1:0]   wr_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   wr_data,
  input  logic                         wr_ack,

  output logic                         rd_req,
  output logic [BRAM_ADDR_WIDTH-1:0]   rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]   rd_data,
  input  logic                         rd_ack,
  input  logic                         rd_valid
);

  localparam int N = (BRAM_DATA_WIDTH + 31) / 32;
  localparam int L = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  typedef struct packed {
    logic                         req;
    logic                         ack;
    logic                         rd_wr_L;
    logic [REG_ADDR_WIDTH-1:0]    addr;
    logic [31:0]                  data;
    logic [UDP_REG_SRC_WIDTH-1:0] src;
  } ring_t;

  state_t                       state_q, state_n;
  ring_t                        ring_in, ring_q, ring_n;
  ring_t                        held_q, held_n;
  ring_t                        echo, resp;
  logic [BRAM_DATA_WIDTH-1:0]   shadow_q, shadow_n, shadow_wr;
  logic                         wr_req_n, rd_req_n;
  logic [BRAM_ADDR_WIDTH-1:0]   wr_addr_n, rd_addr_n;
  logic [BRAM_DATA_WIDTH-1:0]   wr_data_n;
  logic [15:0]                  wd_q, wd_n;
  logic [15:0]                  tmo_q, tmo_n;
  logic [31:0]                  rd_word;

  logic                         hit;
  logic [L-1:0]                 lane_in, held_lane;
  logic [BRAM_ADDR_WIDTH-1:0]   entry_in;
  logic                         wd_expired;

  assign ring_in = '{req: reg_req_in, ack: reg_ack_in, rd_wr_L: reg_rd_wr_L_in,
                     addr: reg_addr_in, data: reg_data_in, src: reg_src_in};

  assign lane_in    = reg_addr_in[L-1:0];
  assign entry_in   = reg_addr_in[L+BRAM_ADDR_WIDTH-1:L];
  assign held_lane  = held_q.addr[L-1:0];
  assign hit        = reg_req_in && !reg_ack_in &&
                      (reg_addr_in[REG_ADDR_WIDTH-1 -: TAG_WIDTH] == TAG_ADDR);
  assign wd_expired = (wd_q == 16'(TIMEOUT_CYCLES - 1));

  // Incoming request answered in place, and the captured request answered
  // after the BRAM handshake.
  always_comb begin
    echo     = ring_in;
    echo.ack = 1'b1;
    resp     = held_q;
    resp.req = 1'b1;
    resp.ack = 1'b1;
  end

  // Lane insert into the shadow word and lane extract from read data.
  // Working bit by bit truncates the top lane to the real word width.
  always_comb begin
    shadow_wr = shadow_q;
    rd_word   = '0;
    for (int b = 0; b < BRAM_DATA_WIDTH; b++) begin
      if (lane_in == L'(b / 32))   shadow_wr[b]      = reg_data_in[b % 32];
      if (held_lane == L'(b / 32)) rd_word[b % 32]   = rd_data[b];
    end
  end

  // NOTE: every variable gets a default before the case statement, so no
  // path through this block can leave a value unassigned and infer a latch.
  always_comb begin
    state_n   = state_q;
    ring_n    = '0;
    held_n    = held_q;
    shadow_n  = shadow_q;
    wr_req_n  = wr_req;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    rd_req_n  = rd_req;
    rd_addr_n = rd_addr;
    wd_n      = wd_q;
    tmo_n     = tmo_q;

    case (state_q)
      IDLE: begin
        if (hit) begin
          if (!reg_rd_wr_L_in) begin
            if (lane_in < L'(N)) begin
              shadow_n = shadow_wr;
              ring_n   = echo;
            end else if (lane_in == L'(N) && reg_data_in == 32'h1) begin
              held_n    = ring_in;
              wr_req_n  = 1'b1;
              wr_addr_n = entry_in;
              wr_data_n = shadow_q;
              wd_n      = '0;
              state_n   = WRITE;
            end else begin
              ring_n = echo;
            end
          end else begin
            if (lane_in < L'(N)) begin
              held_n    = ring_in;
              rd_req_n  = 1'b1;
              rd_addr_n = entry_in;
              wd_n      = '0;
              state_n   = READ;
            end else if (lane_in == L'(N)) begin
              ring_n      = echo;
              ring_n.data = {tmo_q, 16'h0};
            end else begin
              ring_n = echo;
            end
          end
        end else if (reg_req_in) begin
          // Foreign or already-acknowledged request: forward untouched.
          ring_n = ring_in;
        end
      end

      WRITE: begin
        if (wr_ack) begin
          wr_req_n = 1'b0;
          ring_n   = resp;
          state_n  = DONE;
        end else if (wd_expired) begin
          wr_req_n    = 1'b0;
          ring_n      = resp;
          ring_n.data = 32'hDEADBEEF;
          tmo_n       = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
          state_n     = IDLE;
        end else begin
          wd_n = wd_q + 16'd1;
        end
      end

      READ: begin
        // rd_valid completes the read whether or not rd_ack was ever seen.
        if (rd_valid) begin
          rd_req_n    = 1'b0;
          ring_n      = resp;
          ring_n.data = rd_word;
          state_n     = IDLE;
        end else if (wd_expired) begin
          rd_req_n    = 1'b0;
          ring_n      = resp;
          ring_n.data = 32'hDEADBEEF;
          tmo_n       = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
          state_n     = IDLE;
        end else begin
          wd_n = wd_q + 16'd1;
          if (rd_ack) rd_req_n = 1'b0;
        end
      end

      // One settling cycle after the write acknowledge has gone out.
      DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ring_q   <= '0;
      held_q   <= '0;
      // NOTE: the shadow word is register state rather than RAM, so it is
      // cleared here along with everything else.
      shadow_q <= '0;
      wr_req   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      wd_q     <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_n;
      ring_q   <= ring_n;
      held_q   <= held_n;
      shadow_q <= shadow_n;
      wr_req   <= wr_req_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      rd_req   <= rd_req_n;
      rd_addr  <= rd_addr_n;
      wd_q     <= wd_n;
      tmo_q    <= tmo_n;
    end
  end

  assign reg_req_out     = ring_q.req;
  assign reg_ack_out     = ring_q.ack;
  assign reg_rd_wr_L_out = ring_q.rd_wr_L;
  assign reg_addr_out    = ring_q.addr;
  assign reg_data_out    = ring_q.data;
  assign reg_src_out     = ring_q.src;

endmodule

// File: doc/bram_reg_access_gen.md
BRAM_REG_ACCESS_GEN -- requirements
Module: bram_reg_access_gen

Interface
REQ-001 SHALL have parameter UDP_REG_SRC_WIDTH, default 2: register-ring source tag width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 23: register-ring address width.
REQ-003 SHALL have parameter TAG_WIDTH, default 10: block-select field width, reg_addr_in[REG_ADDR_WIDTH-1 -: TAG_WIDTH].
REQ-004 SHALL have parameter TAG_ADDR, default 10'h025: block-select value.
REQ-005 SHALL have parameter BRAM_ADDR_WIDTH, default 10: BRAM entry index width.
REQ-006 SHALL have parameter BRAM_DATA_WIDTH, default 72: BRAM word width, range 1..256.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 255: BRAM handshake watchdog limit, range 1..65535.
REQ-008 Derived: N = ceil(BRAM_DATA_WIDTH/32) data lanes; L = clog2(N+1) lane bits; TAG_WIDTH+BRAM_ADDR_WIDTH+L <= REG_ADDR_WIDTH.
REQ-009 clk  in  1  clock; all logic on rising edge.
REQ-010 reset  in  1  synchronous, active-high.
REQ-011 reg_req_in / reg_ack_in / reg_rd_wr_L_in  in  1 each  ring request, ack, read(1)/write(0).
REQ-012 reg_addr_in  in  REG_ADDR_WIDTH; reg_data_in  in  32; reg_src_in  in  UDP_REG_SRC_WIDTH.
REQ-013 reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out  out  registered ring outputs, same widths as inputs.
REQ-014 wr_req out 1; wr_addr out BRAM_ADDR_WIDTH; wr_data out BRAM_DATA_WIDTH; wr_ack in 1.
REQ-015 rd_req out 1; rd_addr out BRAM_ADDR_WIDTH; rd_data in BRAM_DATA_WIDTH; rd_ack in 1; rd_valid in 1.

Function
REQ-016 Hit = reg_req_in & tag match & !reg_ack_in; entry = reg_addr_in[L+BRAM_ADDR_WIDTH-1:L]; lane = reg_addr_in[L-1:0].
REQ-017 Non-hit request in IDLE: all six ring inputs copied to outputs with 1-cycle latency; no request: ring outputs 0.
REQ-018 Tag match with reg_ack_in=1: passed through unchanged (already serviced).
REQ-019 States IDLE, WRITE, READ, DONE; reset state IDLE.
REQ-020 Hit write, lane<N: write shadow lane bits [32*lane +: 32] from reg_data_in (top lane truncated to BRAM_DATA_WIDTH-32*(N-1) bits); ack out next cycle with data echoed; stay IDLE.
REQ-021 Hit write, lane==N, data==32'h1: capture request into held regs; next cycle wr_req=1, wr_addr=entry, wr_data=shadow; go WRITE.
REQ-022 Hit write, lane==N, other data, or any hit with lane>N: ack out next cycle, data echoed, no BRAM access.
REQ-023 Hit read, lane<N: capture request; next cycle rd_req=1, rd_addr=entry; go READ.
REQ-024 Hit read, lane==N: ack out next cycle, reg_data_out = {timeout_count[15:0], 16'h0}.
REQ-025 WRITE: on wr_ack, wr_req=0 next cycle, go DONE; DONE emits held request with ack=1 for one cycle, then IDLE.
REQ-026 READ: on rd_ack, rd_req=0; on rd_valid (same or later cycle than rd_ack, or without rd_ack), rd_req=0, held request emitted next cycle with ack=1, reg_data_out = rd_data lane zero-extended to 32 bits; go IDLE.
REQ-027 Watchdog: counter cleared on entering WRITE/READ, increments per cycle; reaching TIMEOUT_CYCLES without completion drops wr_req/rd_req, emits held request with ack=1, reg_data_out=32'hDEADBEEF, timeout_count+1 saturating at 16'hFFFF, go IDLE.
REQ-028 Ring inputs arriving while not IDLE are dropped (single outstanding transaction); shadow unaffected.
REQ-029 wr_data/wr_addr/rd_addr hold stable while corresponding req is high.

Reset
REQ-030 On reset: all ring outputs, wr_req, wr_addr, wr_data, rd_req, rd_addr 0; shadow, held regs, watchdog, timeout_count 0; state IDLE; applies mid-transaction, in-flight request abandoned without ack.

Verification
REQ-031 Write lanes 0,1,2 of entry 5 with 32'h11111111, 32'h22222222, 32'h000000AB, then lane 3 with 32'h1 -> wr_req, wr_addr=5, wr_data=72'hAB_22222222_11111111; wr_ack -> ack out 1 cycle later.
REQ-032 Read lane 2 of entry 5, rd_ack+rd_valid same cycle, rd_data=72'hAB_... -> ack out next cycle, reg_data_out=32'h000000AB.
REQ-033 Non-hit read, addr tag 10'h001 -> identical outputs 1 cycle later, no rd_req.
REQ-034 Read lane 0, never ack -> after 255 cycles rd_req=0, reg_data_out=32'hDEADBEEF; lane-3 read returns 32'h00010000.
REQ-035 Reset asserted while in WRITE -> wr_req=0, state IDLE, no ack; subsequent hit serviced normally.
REQ-036 Tag-hit request with reg_ack_in=1 -> passed through unchanged, no BRAM access.
